// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: loads a 128-bit state, transforms COLS_PER_CYCLE
// columns per cycle in place, then holds the result under valid/ready backpressure.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } fsm_e;

  // Column counter step and the start column of the final group; both wrap in 2 bits.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  fsm_e         fsm_q, fsm_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] state_q, state_d;
  logic [127:0] mixed;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are s0 (row 0) in [31:24] down to s3 (row 3) in [7:0].
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] s  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      x2    = xtime(s[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Replace only the columns of the current group; the rest pass through.
  always_comb begin
    logic [31:0] col;
    logic [31:0] res;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    mixed = state_q;
    col   = '0;
    res   = '0;
    for (int c = 0; c < 4; c++) begin
      if (c >= int'(col_cnt_q) && c < int'(col_cnt_q) + COLS_PER_CYCLE) begin
        col = {state_q[127-8*c -: 8], state_q[95-8*c -: 8],
               state_q[63-8*c -: 8],  state_q[31-8*c -: 8]};
        res = inv_mix_col(col);
        mixed[127-8*c -: 8] = res[31:24];
        mixed[95-8*c -: 8]  = res[23:16];
        mixed[63-8*c -: 8]  = res[15:8];
        mixed[31-8*c -: 8]  = res[7:0];
      end
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    col_cnt_d = col_cnt_q;
    state_d   = state_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d   = in_data;
          col_cnt_d = '0;
          fsm_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        state_d = mixed;
        if (col_cnt_q == LAST) begin
          col_cnt_d = '0;
          fsm_d     = S_DONE;
        end else begin
          col_cnt_d = col_cnt_q + STEP;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d   = in_data;
            col_cnt_d = '0;
            fsm_d     = S_BUSY;
          end else begin
            fsm_d = S_IDLE;
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // NOTE: the state register is cleared on reset so a discarded operation never leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= S_IDLE;
      col_cnt_q <= '0;
      state_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      fsm_q     <= fsm_d;
      col_cnt_q <= col_cnt_d;
      state_q   <= state_d;
    end
  end

  assign in_ready  = (fsm_q == S_IDLE) || (fsm_q == S_DONE && out_ready);
  assign out_valid = (fsm_q == S_DONE);
  assign busy      = (fsm_q == S_BUSY) || (fsm_q == S_DONE);
  assign out_data  = (fsm_q == S_DONE) ? state_q : '0;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4, with a
// forward-MixColumns model to confirm round-trips on random states.
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];

  int checks   = 0;
  int failures = 0;

  // Rows are packed row-major: {row0, row1, row2, row3}, each row {c0, c1, c2, c3}.
  localparam logic [127:0] A_IN  = 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc;
  localparam logic [127:0] A_OUT = 128'hdbdbdbdb_13131313_53535353_45454545;
  localparam logic [127:0] B_IN  = 128'h9fd5014d_dcd5017e_58d701bd_9dd601f8;
  localparam logic [127:0] B_OUT = 128'hf2d4012d_0ad40126_22d40131_5cd5014c;

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0])
  );

  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1])
  );

  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns: the inverse of the DUT, so fwd_mix(out) must equal in.
  function automatic logic [127:0] fwd_mix(input logic [127:0] st);
    logic [127:0] o;
    logic [7:0] s0, s1, s2, s3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      s0 = st[127-8*c -: 8];
      s1 = st[95-8*c -: 8];
      s2 = st[63-8*c -: 8];
      s3 = st[31-8*c -: 8];
      o[127-8*c -: 8] = xt(s0) ^ (xt(s1) ^ s1) ^ s2 ^ s3;
      o[95-8*c -: 8]  = s0 ^ xt(s1) ^ (xt(s2) ^ s2) ^ s3;
      o[63-8*c -: 8]  = s0 ^ s1 ^ xt(s2) ^ (xt(s3) ^ s3);
      o[31-8*c -: 8]  = (xt(s0) ^ s0) ^ s1 ^ s2 ^ xt(s3);
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Wait (bounded) for out_valid; lat counts rising edges after the accept edge.
  task automatic wait_valid(input int idx, inout int lat);
    while (!out_valid[idx] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain(input int idx);
    out_ready[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready[idx] = 1'b0;
  endtask

  task automatic do_txn(input int idx, input logic [127:0] d,
                        output logic [127:0] res, output int lat);
    @(negedge clk);
    in_data[idx]  = d;
    in_valid[idx] = 1'b1;
    check("accept_in_ready", 128'(in_ready[idx]), 128'd1);
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    in_data[idx]  = rand128();
    lat = 0;
    wait_valid(idx, lat);
    res = out_data[idx];
    drain(idx);
  endtask

  initial begin
    int lat;
    int lat_exp [3];
    logic [127:0] res;
    logic [127:0] d;

    lat_exp[0] = 4;
    lat_exp[1] = 2;
    lat_exp[2] = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b0;
    end
    rst_n = 1'b0;
    #23;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_in_ready",  128'(in_ready[i]),  128'd1);
      check("reset_out_valid", 128'(out_valid[i]), 128'd0);
      check("reset_busy",      128'(busy[i]),      128'd0);
      check("reset_out_data",  out_data[i],        128'd0);
    end

    // Directed vectors on every width, including per-row layout.
    for (int i = 0; i < 3; i++) begin
      do_txn(i, A_IN, res, lat);
      check("vecA_data", res, A_OUT);
      check("vecA_latency", 128'(lat), 128'(lat_exp[i]));
      do_txn(i, B_IN, res, lat);
      check("vecB_latency", 128'(lat), 128'(lat_exp[i]));
      for (int r = 0; r < 4; r++) begin
        d = B_OUT;
        check($sformatf("vecB_row%0d", r), 128'(res[127-32*r -: 32]), 128'(d[127-32*r -: 32]));
      end
    end

    // Backpressure: result held for 10 cycles, then back-to-back accept.
    @(negedge clk);
    in_data[0]  = A_IN;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    wait_valid(0, lat);
    check("hold_latency", 128'(lat), 128'd4);
    repeat (10) begin
      @(posedge clk); #1;
      check("hold_data",     out_data[0],         A_OUT);
      check("hold_valid",    128'(out_valid[0]),  128'd1);
      check("hold_in_ready", 128'(in_ready[0]),   128'd0);
    end
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = B_IN;
    #1;
    check("b2b_in_ready", 128'(in_ready[0]), 128'd1);
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    in_data[0]   = rand128();
    check("b2b_busy",      128'(busy[0]),      128'd1);
    check("b2b_out_valid", 128'(out_valid[0]), 128'd0);
    lat = 0;
    wait_valid(0, lat);
    check("b2b_latency", 128'(lat), 128'd4);
    check("b2b_data", out_data[0], B_OUT);
    drain(0);

    // in_valid pulsed while BUSY must be ignored.
    @(negedge clk);
    in_data[0]  = A_IN;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    check("busy_in_ready", 128'(in_ready[0]), 128'd0);
    in_data[0] = B_IN;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 2;
    wait_valid(0, lat);
    check("busy_pulse_latency", 128'(lat), 128'd4);
    check("busy_pulse_data", out_data[0], A_OUT);
    drain(0);

    // Round-trip on random states.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < (i == 0 ? 1000 : 200); n++) begin
        d = rand128();
        do_txn(i, d, res, lat);
        check("rand_roundtrip", fwd_mix(res), d);
      end
    end

    // Asynchronous reset mid-BUSY.
    @(negedge clk);
    in_data[0]  = A_IN;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_busy", 128'(busy[0]), 128'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy",      128'(busy[0]),      128'd0);
    check("async_rst_out_valid", 128'(out_valid[0]), 128'd0);
    check("async_rst_out_data",  out_data[0],        128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 128'(in_ready[0]), 128'd1);
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_stale_valid", 128'(out_valid[0]), 128'd0);
    do_txn(0, B_IN, res, lat);
    check("post_rst_data", res, B_OUT);
    check("post_rst_latency", 128'(lat), 128'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
